// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, PS/2 command bytes and the microsecond-to-cycle helper
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;
    function automatic int us_to_cyc(input int hz, input int us);
        return (hz / 1000) * us / 1000;
    endfunction
endpackage

// File: rtl/ps2out_if.sv
// ps2out_if: command handshake between system logic and the PS/2 transmitter
interface ps2out_if;
    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       done;
    logic       err;
    modport master (output send, data, input ready, done, err);
    modport slave (input send, data, output ready, done, err);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for a PS/2 pin plus falling-edge detect
module ps2_line_sync (
    input  logic clk,
    input  logic res,
    input  logic pin,
    output logic lvl,
    output logic fe
);
    logic [2:0] sr;
    // two sync stages, third stage holds the previous synchronized level; idle lines read high
    always_ff @(posedge clk)
        sr <= !res ? 3'b111 : {sr[1:0], pin};
    assign lvl = sr[1];
    assign fe  = sr[2] & ~sr[1];
endmodule

// File: rtl/ps2out.sv
// ps2out: PS/2 host-to-device transmitter; define PS2OUT_TIMEOUT_EN to add the frame timeout abort
module ps2out
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25_152_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000
) (
    input  logic     clk,
    input  logic     res,
    ps2out_if.slave  bus,
    input  logic     ps2clk_in,
    input  logic     ps2data_in,
    output logic     ps2clk_oe,
    output logic     ps2data_oe
);
    localparam int INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
    localparam int CW = $clog2(INHIBIT_CYC);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [9:0]    frame;
    logic          drive, ack_ok, tmo;
    logic          clk_lvl, clk_fe, dat_lvl, unused_dat_fe;

    ps2_line_sync u_clk (.clk(clk), .res(res), .pin(ps2clk_in), .lvl(clk_lvl), .fe(clk_fe));
    ps2_line_sync u_dat (.clk(clk), .res(res), .pin(ps2data_in), .lvl(dat_lvl), .fe(unused_dat_fe));

`ifdef PS2OUT_TIMEOUT_EN
    localparam int TIMEOUT_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    // elapsed cycles since the clock line was released to the device
    always_ff @(posedge clk)
        tcnt <= (!res || state inside {IDLE, INHIBIT, REQ}) ? '0 : tcnt + 1'b1;
    assign tmo = tcnt == TW'(TIMEOUT_CYC);
`else
    assign tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge clk)
        state <= !res ? IDLE : nxt;

    // next state and the end-of-transfer report
    always_comb begin
        nxt      = state;
        bus.done = 1'b0;
        bus.err  = 1'b0;
        if (tmo) begin
            nxt      = IDLE;
            bus.done = 1'b1;
            bus.err  = 1'b1;
        end else begin
            case (state)
                IDLE:      nxt = bus.send ? INHIBIT : IDLE;
                INHIBIT:   nxt = cnt == INH_LAST ? REQ : INHIBIT;
                REQ:       nxt = BITS;
                BITS:      nxt = (clk_fe && idx == 4'd9) ? ACK : BITS;
                ACK:       nxt = clk_fe ? WAIT_IDLE : ACK;
                WAIT_IDLE: begin
                    if (clk_lvl && dat_lvl) begin
                        nxt      = IDLE;
                        bus.done = 1'b1;
                        bus.err  = ~ack_ok;
                    end
                end
                default:   nxt = IDLE;
            endcase
        end
    end

    // frame shifter: start bit driven from REQ, one bit advanced per device falling edge
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            drive  <= 1'b0;
            ack_ok <= 1'b0;
        end else begin
            cnt    <= state == INHIBIT ? cnt + 1'b1 : '0;
            idx    <= state != BITS ? 4'd0 : idx + 4'(clk_fe);
            frame  <= (state == IDLE && bus.send) ? {1'b1, ~^bus.data, bus.data} : frame;
            drive  <= nxt == IDLE ? 1'b0 : nxt == REQ ? 1'b1 : (state == BITS && clk_fe) ? ~frame[idx] : drive;
            ack_ok <= (state == ACK && clk_fe) ? ~dat_lvl : ack_ok;
        end
    end

    assign bus.ready  = state == IDLE;
    assign ps2clk_oe  = state == INHIBIT || state == REQ;
    assign ps2data_oe = drive & ~tmo;
endmodule

// File: tb/tb_ps2out.sv
// tb_ps2out: self-checking bench for ps2out with an open-drain PS/2 device model
module tb_ps2out;
    import ps2_pkg::*;

    localparam int INH_EXP = 2516;
    localparam int TO_EXP  = 10060;

    typedef struct {
        logic [7:0] b;
        bit         ack;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic ps2clk_oe, ps2data_oe;
    logic dev_clk = 1'b0;
    logic dev_dat = 1'b0;
    wire  pclk = ~(ps2clk_oe | dev_clk);
    wire  pdat = ~(ps2data_oe | dev_dat);
    int   cmp = 0;
    int   bad = 0;
    vec_t tbl [9];

    ps2out_if bus ();

    ps2out #(.TIMEOUT_US(400)) dut (
        .clk(clk), .res(res), .bus(bus),
        .ps2clk_in(pclk), .ps2data_in(pdat),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [9:0] line_bits(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    always @(negedge clk) check("err_without_done", bus.err & ~bus.done, 1'b0);

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit exp_err,
                             input bit keep, input bit pulse, input int abort_at);
        int n, half;
        logic [9:0] got, exp;
        half = $urandom_range(30, 80);
        exp = line_bits(b);
        got = '0;
        bus.data = b;
        bus.send = 1'b1;
        n = 0;
        while (!ps2clk_oe && n < 20) begin tick(); n++; end
        check("accept", {bus.ready, ps2clk_oe}, 2'b01);
        bus.send = keep;
        n = 0;
        while (ps2clk_oe && n < 5000) begin tick(); n++; end
        check("inhibit_len", n, INH_EXP);
        tick(half);
        check("start_bit", pdat, 1'b0);
        for (int k = 0; k < 11; k++) begin
            if (abort_at != 0 && k == abort_at) begin
                res = 1'b0;
                tick();
                check("abort_state", {ps2clk_oe, ps2data_oe, bus.ready, bus.done}, 4'b0010);
                res = 1'b1;
                tick(4);
                check("abort_no_done", {bus.ready, bus.done}, 2'b10);
                return;
            end
            if (k == 10) begin
                dev_dat = ack;
                tick(half / 2);
            end
            dev_clk = 1'b1;
            if (k == 0 && exp[0]) begin
                n = 0;
                while (ps2data_oe && n < 10) begin tick(); n++; end
                check("fe_to_oe", n, 3);
                tick(half - n);
            end else begin
                tick(half);
            end
            if (pulse && k == 4) begin
                bus.data = 8'h00;
                bus.send = 1'b1;
                tick();
                check("busy_ignore", bus.ready, 1'b0);
                bus.send = 1'b0;
            end
            dev_clk = 1'b0;
            dev_dat = 1'b0;
            if (k < 10) begin
                got[k] = pdat;
                tick(half);
            end
        end
        check("line_bits", got, exp);
        n = 0;
        while (!bus.done && n < 50) begin tick(); n++; end
        check("done", bus.done, 1'b1);
        check("err", bus.err, exp_err);
        tick();
        check("ready_after", {bus.ready, bus.done}, 2'b10);
    endtask

    initial begin
        int n;
        bus.send = 1'b0;
        bus.data = 8'h00;
        tbl[0] = '{CMD_SET_LEDS, 1'b1, 1'b0};
        tbl[1] = '{CMD_RESET, 1'b1, 1'b0};
        tbl[2] = '{CMD_ENABLE, 1'b1, 1'b0};
        tbl[3] = '{ACK_BYTE, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b0};
        for (int i = 5; i < 9; i++) begin
            tbl[i].b = 8'($urandom);
            tbl[i].ack = 1'($urandom);
            tbl[i].exp_err = ~tbl[i].ack;
        end

        tick(4);
        check("reset_outs", {bus.ready, bus.done, bus.err, ps2clk_oe, ps2data_oe}, 5'b10000);
        res = 1'b1;
        tick(2);
        check("idle_outs", {bus.ready, bus.done, bus.err, pclk, pdat}, 5'b10011);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].b, tbl[i].ack, tbl[i].exp_err, 1'b0, 1'b0, 0);
            tick(20);
        end

        run_frame(CMD_RESET, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        tick(20);
        run_frame(CMD_RESET, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_frame(CMD_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(20);

        run_frame(CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        tick(20);
        run_frame(CMD_ENABLE, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(20);

        bus.data = CMD_RESET;
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        n = 0;
        while (ps2clk_oe && n < 5000) begin tick(); n++; end
        n = 0;
        while (!bus.done && n < TO_EXP + 2000) begin tick(); n++; end
`ifdef PS2OUT_TIMEOUT_EN
        check("timeout_cycle", n, TO_EXP);
        check("timeout_err", {bus.done, bus.err}, 2'b11);
        check("timeout_lines", {ps2clk_oe, ps2data_oe}, 2'b00);
        tick();
        check("timeout_ready", {bus.ready, pclk, pdat}, 3'b111);
`else
        check("no_timeout_done", bus.done, 1'b0);
        check("no_timeout_busy", {bus.ready, ps2data_oe}, 2'b01);
        res = 1'b0;
        tick(2);
        res = 1'b1;
        tick(2);
        check("no_timeout_reset", {bus.ready, ps2clk_oe, ps2data_oe}, 3'b100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/ps2out.md
# ps2out

Host-to-device PS/2 transmitter: the send side of the keyboard link that `ps2in` receives on. It takes one command byte from system logic, such as 0xED set-LEDs, 0xFF reset or 0xF4 enable. It performs the PS/2 request-to-send sequence on the open-drain clock and data lines, serialises the frame on device-generated clocks, checks the device acknowledge and reports done/err. It sits beside `ps2in` at the top level and shares the same PS2 pins through external open-drain buffers.

## Interface
Parameters:
- `CLK_HZ`, 25_152_000: system clock frequency.
- `INHIBIT_US`, 100: clock-inhibit duration before the start bit.
- `TIMEOUT_US`, 15_000: maximum time from clock release to frame end.

Ports:
- `clk` in 1: system clock. One clock domain.
- `res` in 1: reset. Synchronous, active-low.
- `send` in 1: request. Accepted only when `ready`=1.
- `data` in 8: command byte. Captured on the accept cycle.
- `ready` out 1: idle; a new byte can be accepted.
- `done` out 1: one-cycle pulse at transfer end.
- `err` out 1: valid with `done`. 1 means no acknowledge or timeout.
- `ps2clk_in` in 1: PS2 clock pin level (asynchronous).
- `ps2data_in` in 1: PS2 data pin level (asynchronous).
- `ps2clk_oe` out 1: 1 pulls the PS2 clock low; 0 releases it.
- `ps2data_oe` out 1: 1 pulls PS2 data low; 0 releases it.

## Operation
- Inputs `ps2clk_in` and `ps2data_in` each pass through a 2-flop synchronizer. A falling edge `fe` is the synchronized previous value 1 and current value 0.
- Derived constants:
  - INHIBIT_CYC = (CLK_HZ/1000)*INHIBIT_US/1000, which is 2515 at the defaults.
  - TIMEOUT_CYC is computed the same way, which is 377_280 at the defaults.
- Parity bit = ~^data (odd parity).
- Drive rule: `ps2data_oe` = ~bit, so a 0 bit pulls the line low and a 1 bit releases it.
- States:
  - IDLE: `ready`=1 and both oe=0. `send` moves to INHIBIT, latches `data`, computes parity and clears counters.
  - INHIBIT: `ps2clk_oe`=1 and `ps2data_oe`=0 for INHIBIT_CYC cycles, then REQ.
  - REQ: one cycle with `ps2clk_oe`=1 and `ps2data_oe`=1 (start bit), then BITS with idx=0. `ps2clk_oe` drops to 0; the start bit stays driven.
  - BITS: on each `fe`, drive bit idx and increment idx:
    - idx 0–7: data bits, LSB first.
    - idx 8: parity.
    - idx 9: stop bit (release data).
    - After the idx 9 edge, go to ACK.
  - ACK: on the next `fe` (the 11th), sample synchronized data. 0 means acknowledge. Latch ack_ok, then WAIT_IDLE.
  - WAIT_IDLE: when synchronized clock=1 and data=1, pulse `done` with `err`=~ack_ok, then IDLE.
- Timeout: a counter runs from REQ exit through WAIT_IDLE. When it reaches TIMEOUT_CYC, both oe go to 0, `done`=1, `err`=1, next state IDLE.
- `send` while `ready`=0 is ignored and has no queue.
- `data` changes after accept are ignored.

## Timing
- Reset values: `ready`=1, `done`=0, `err`=0, `ps2clk_oe`=0, `ps2data_oe`=0. State IDLE; counters and idx are 0.
- Accept cycle is N. Registers update at N+1: `ready`=0 and `ps2clk_oe`=1.
- `ps2clk_oe` stays high for INHIBIT_CYC+1 cycles, counting INHIBIT plus REQ.
- The `ps2data_oe` update follows the pin falling edge by 3 clk cycles (2 sync + 1 register), well inside the device low phase of at least 30 µs.
- `done` and `err` are valid for exactly one cycle. `ready`=1 in the cycle after `done`.
- `send` held high continuously starts the next transfer in that same `ready` cycle.
- Reset mid-transfer: both lines are released on the next clk edge. No `done` is generated.
- `err` is 0 whenever `done`=0.

## Configuration
- Macro `PS2OUT_TIMEOUT_EN`.
- Defined: the timeout counter and abort path exist as described above.
- Undefined:
  - No counter beyond the inhibit counter.
  - The FSM waits indefinitely for device clocks.
  - `err` reflects only a missing acknowledge.
  - `TIMEOUT_US` is unused.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE);
  - command byte constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA;
  - a function that converts microseconds to cycles.
- Sub-module `ps2_line_sync`: 2-flop synchronizer plus falling-edge detect. Instantiated once each for clock and data.

## Test plan
1. Assert `res`=0 for 4 cycles. Expect `ready`=1, `done`=0, `err`=0 and both oe=0, with no activity on the lines.
2. `send` 0xED with a device model clocking at 12 kHz that acknowledges:
   - `ps2clk_oe` is high for 2516 cycles.
   - Sampled bits, LSB first, are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
   - `done`=1 with `err`=0.
3. Device model releases data on the 11th edge (no acknowledge): `done`=1 with `err`=1, and `ready`=1 the next cycle.
4. Device never clocks, with `PS2OUT_TIMEOUT_EN`: `done` and `err`=1 exactly 377_280 cycles after REQ exit, and lines released. Without the macro, the block remains busy with no `done`.
5. `send` 0xFF, then pulse `send` with 0x00 during BITS: the second request is ignored and only 0xFF appears on the line. `send` held high gives two back-to-back 0xFF frames.
6. Assert `res`=0 at bit idx 4: both oe=0 on the next cycle and `ready`=1. A following `send` of 0xF4 completes normally.
